// File: rtl/key_zone_scanner_if.sv
// Pixel-in / key-state-out bundle for key_zone_scanner.
// The source drives the pixel stream; the scanner drives the key results.
interface key_zone_scanner_if #(
  parameter int NUM_KEYS = 8
);
  logic                frame_start;
  logic                pix_valid;
  logic [8:0]          pix_data;
  logic [NUM_KEYS-1:0] key_mask;
  logic [NUM_KEYS-1:0] key_down;
  logic [NUM_KEYS-1:0] key_up;
  logic                frame_done;
  logic                frame_err;
  logic                busy;
  logic [31:0]         debug_out;

  modport master (
    output frame_start, pix_valid, pix_data,
    input  key_mask, key_down, key_up, frame_done, frame_err, busy, debug_out
  );

  modport slave (
    input  frame_start, pix_valid, pix_data,
    output key_mask, key_down, key_up, frame_done, frame_err, busy, debug_out
  );
endinterface

// File: rtl/key_zone_scanner.sv
// Counts dark RGB333 pixels per zone inside a horizontal band and turns the
// per-frame counts into a debounced key mask with press/release pulses.
module key_zone_scanner #(
  parameter int H_RES         = 320,
  parameter int V_RES         = 240,
  parameter int NUM_KEYS      = 8,
  parameter int ROW_TOP       = 200,
  parameter int ROW_BOT       = 219,
  parameter int DARK_TH       = 6,
  parameter int COUNT_TH      = 400,
  parameter int STABLE_FRAMES = 2
) (
  input logic             clk,
  input logic             rst,
  key_zone_scanner_if.slave bus
);
  localparam int ZONE_W = H_RES / NUM_KEYS;
  localparam int XW     = $clog2(H_RES);
  localparam int YW     = $clog2(V_RES);
  localparam int ZW     = $clog2(NUM_KEYS);
  localparam int SW     = (ZONE_W > 1) ? $clog2(ZONE_W) : 1;
  localparam int BW     = $clog2(STABLE_FRAMES + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] EVAL  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]          state;
  logic [XW-1:0]       x, cx, nx;
  logic [YW-1:0]       y, cy, ny;
  logic [ZW-1:0]       zone, cz, nz;
  logic [SW-1:0]       sub, cs, ns;
  logic                start, take, hit, last, raw;
  logic [4:0]          luma;
  logic [15:0]         dark [NUM_KEYS];
  logic [BW-1:0]       stab [NUM_KEYS];
  logic [ZW-1:0]       k;
  logic [NUM_KEYS-1:0] mask, mask_nxt, acc_down, acc_up, down, up;
  logic                done, err;
  logic [7:0]          frame_cnt;
  logic [15:0]         dark0_last;

  // A frame_start (from IDLE or as a short-frame restart) makes the coincident
  // pixel (0,0): raster position is taken as zero for this cycle.
  always_comb begin
    start = bus.frame_start && (state == IDLE || state == ACCUM);
    take  = bus.pix_valid && (start || state == ACCUM);
    cx    = start ? '0 : x;
    cy    = start ? '0 : y;
    cz    = start ? '0 : zone;
    cs    = start ? '0 : sub;
    luma  = 5'(bus.pix_data[8:6]) + 5'(bus.pix_data[5:3]) + 5'(bus.pix_data[2:0]);
    hit   = take && cy >= YW'(ROW_TOP) && cy <= YW'(ROW_BOT) && luma < 5'(DARK_TH);
    last  = take && cx == XW'(H_RES - 1) && cy == YW'(V_RES - 1);
    nx = cx;
    ny = cy;
    nz = cz;
    ns = cs;
    if (take) begin
      if (cx == XW'(H_RES - 1)) begin
        nx = '0;
        ny = (cy == YW'(V_RES - 1)) ? '0 : cy + YW'(1);
        nz = '0;
        ns = '0;
      end else begin
        nx = cx + XW'(1);
        if (cs == SW'(ZONE_W - 1)) begin
          ns = '0;
          nz = cz + ZW'(1);
        end else begin
          ns = cs + SW'(1);
        end
      end
    end
    raw = dark[k] >= 16'(COUNT_TH);
  end

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_zone
    always_ff @(posedge clk) begin
      if (rst)
        dark[g] <= '0;
      else if (start)
        dark[g] <= (hit && cz == ZW'(g)) ? 16'd1 : 16'd0;
      else if (hit && cz == ZW'(g) && dark[g] != 16'hFFFF)
        dark[g] <= dark[g] + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      zone       <= '0;
      sub        <= '0;
      k          <= '0;
      mask       <= '0;
      mask_nxt   <= '0;
      acc_down   <= '0;
      acc_up     <= '0;
      down       <= '0;
      up         <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      frame_cnt  <= '0;
      dark0_last <= '0;
      for (int i = 0; i < NUM_KEYS; i++) stab[i] <= '0;
    end else begin
      x    <= nx;
      y    <= ny;
      zone <= nz;
      sub  <= ns;
      done <= 1'b0;
      err  <= 1'b0;
      down <= '0;
      up   <= '0;
      case (state)
        IDLE: if (start) state <= ACCUM;
        ACCUM: begin
          if (bus.frame_start) err <= 1'b1;
          if (last) begin
            state    <= EVAL;
            k        <= '0;
            mask_nxt <= mask;
            acc_down <= '0;
            acc_up   <= '0;
          end
        end
        EVAL: begin
          if (bus.frame_start) err <= 1'b1;
          // The published mask holds still during EVAL; changes land in mask_nxt.
          if (raw == mask[k]) begin
            stab[k] <= '0;
          end else if (stab[k] == BW'(STABLE_FRAMES - 1)) begin
            stab[k]     <= '0;
            mask_nxt[k] <= raw;
            acc_down[k] <= raw;
            acc_up[k]   <= ~raw;
          end else begin
            stab[k] <= stab[k] + BW'(1);
          end
          k <= k + ZW'(1);
          if (k == ZW'(NUM_KEYS - 1)) state <= DONE;
        end
        DONE: begin
          done       <= 1'b1;
          mask       <= mask_nxt;
          down       <= acc_down;
          up         <= acc_up;
          frame_cnt  <= frame_cnt + 8'd1;
          dark0_last <= dark[0];
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.key_mask   = mask;
  assign bus.key_down   = down;
  assign bus.key_up     = up;
  assign bus.frame_done = done;
  assign bus.frame_err  = err;
  assign bus.busy       = (state == ACCUM) || (state == EVAL);
  assign bus.debug_out  = {frame_cnt, 8'(mask), dark0_last};
endmodule

// File: tb/tb_key_zone_scanner.sv
// Directed bench for key_zone_scanner on a reduced 32x12 raster (8 zones of
// 4 pixels, band rows 8..10, so a fully dark zone holds 12 dark pixels).
module tb_key_zone_scanner;
  localparam int H  = 32;
  localparam int V  = 12;
  localparam int K  = 8;
  localparam int ZW = H / K;
  localparam int RT = 8;
  localparam int RB = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  key_zone_scanner_if #(.NUM_KEYS(K)) bus ();

  key_zone_scanner #(
    .H_RES(H), .V_RES(V), .NUM_KEYS(K), .ROW_TOP(RT), .ROW_BOT(RB),
    .DARK_TH(6), .COUNT_TH(6), .STABLE_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_cnt;

  // Zones set in black get dpix across the band; zone ez gets its first en
  // band pixels (row-major inside the zone) black; everything else white.
  function automatic logic [8:0] pix_at(int x, int y, logic [7:0] black,
                                        logic [8:0] dpix, int ez, int en);
    int z;
    z = x / ZW;
    if (y >= RT && y <= RB) begin
      if (black[z]) return dpix;
      if (z == ez && ((y - RT) * ZW + x % ZW) < en) return 9'h000;
    end
    return 9'h1FF;
  endfunction

  // lat counts cycles from the cycle the last pixel is presented (that cycle = 0).
  task automatic run_frame(input logic [7:0] black, input logic [8:0] dpix,
                           input int ez, input int en, input int eval_fs,
                           output int lat, output logic [7:0] m, output logic [7:0] dn,
                           output logic [7:0] up, output logic [31:0] dbg,
                           output logic err_seen, output logic stray);
    lat = -1; m = '0; dn = '0; up = '0; dbg = '0; err_seen = 1'b0; stray = 1'b0;
    for (int yy = 0; yy < V; yy++)
      for (int xx = 0; xx < H; xx++) begin
        bus.frame_start = (xx == 0 && yy == 0);
        bus.pix_valid   = 1'b1;
        bus.pix_data    = pix_at(xx, yy, black, dpix, ez, en);
        @(posedge clk); #1;
        if (bus.frame_err) err_seen = 1'b1;
        if (bus.frame_done || bus.key_down != 0 || bus.key_up != 0) stray = 1'b1;
      end
    bus.frame_start = 1'b0; bus.pix_valid = 1'b0; bus.pix_data = '0;
    for (int c = 2; c <= 40 && lat < 0; c++) begin
      bus.frame_start = (c == eval_fs);
      bus.pix_valid   = (c == eval_fs);
      @(posedge clk); #1;
      bus.frame_start = 1'b0; bus.pix_valid = 1'b0;
      if (bus.frame_err) err_seen = 1'b1;
      if (bus.frame_done) begin
        lat = c; m = bus.key_mask; dn = bus.key_down; up = bus.key_up; dbg = bus.debug_out;
      end else if (bus.key_down != 0 || bus.key_up != 0) begin
        stray = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    logic [58:0] outs;
    int lat; logic [7:0] m, dn, up; logic [31:0] dbg; logic es, st;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    outs = {bus.key_mask, bus.key_down, bus.key_up, bus.frame_done, bus.frame_err, bus.busy, bus.debug_out};
    tests++; if (outs !== '0) begin fails++; $display("FAIL reset_outs: got %h want 0", outs); end
    for (int i = 0; i < 50; i++) begin
      bus.frame_start = (i == 0); bus.pix_valid = 1'b1; bus.pix_data = 9'h000;
      @(posedge clk); #1;
    end
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL busy_accum: got %b want 1", bus.busy); end
    rst = 1'b1; bus.frame_start = 1'b0;
    @(posedge clk); #1;
    outs = {bus.key_mask, bus.key_down, bus.key_up, bus.frame_done, bus.frame_err, bus.busy, bus.debug_out};
    tests++; if (outs !== '0) begin fails++; $display("FAIL reset_mid: got %h want 0", outs); end
    rst = 1'b0; exp_cnt = 8'd0;
    st = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.busy || bus.frame_done || bus.frame_err) st = 1'b1;
    end
    bus.pix_valid = 1'b0;
    tests++; if (st !== 1'b0) begin fails++; $display("FAIL idle_ignore: got %b want 0", st); end
    run_frame(8'h00, 9'h000, -1, 0, 0, lat, m, dn, up, dbg, es, st);
    exp_cnt++;
    tests++; if (lat !== 10) begin fails++; $display("FAIL reset_frame_lat: got %0d want 10", lat); end
    tests++; if (dbg !== {exp_cnt, 8'h00, 16'h0000}) begin fails++; $display("FAIL reset_frame_dbg: got %h want %h", dbg, {exp_cnt, 24'h0}); end
  endtask

  task automatic test_white();
    int lat; logic [7:0] m, dn, up; logic [31:0] dbg; logic es, st;
    for (int f = 0; f < 3; f++) begin
      run_frame(8'h00, 9'h000, -1, 0, 0, lat, m, dn, up, dbg, es, st);
      exp_cnt++;
      tests++; if (lat !== 10) begin fails++; $display("FAIL white_lat f%0d: got %0d want 10", f, lat); end
      tests++; if ({m, dn, es, st} !== '0) begin fails++; $display("FAIL white_mask f%0d: got m=%h dn=%h err=%b stray=%b want 0", f, m, dn, es, st); end
      tests++; if (dbg !== {exp_cnt, 24'h0}) begin fails++; $display("FAIL white_dbg f%0d: got %h want %h", f, dbg, {exp_cnt, 24'h0}); end
    end
  endtask

  task automatic test_zone2();
    int lat; logic [7:0] m, dn, up; logic [31:0] dbg; logic es, st;
    run_frame(8'h04, 9'h000, -1, 0, 0, lat, m, dn, up, dbg, es, st);
    exp_cnt++;
    tests++; if ({m, dn} !== 16'h0000) begin fails++; $display("FAIL zone2_f1: got m=%h dn=%h want 00/00", m, dn); end
    tests++; if (dbg !== {exp_cnt, 24'h0}) begin fails++; $display("FAIL zone2_f1_dbg: got %h want %h", dbg, {exp_cnt, 24'h0}); end
    run_frame(8'h04, 9'h000, -1, 0, 0, lat, m, dn, up, dbg, es, st);
    exp_cnt++;
    tests++; if ({lat, m, dn, up, st} !== {32'd10, 8'h04, 8'h04, 8'h00, 1'b0}) begin
      fails++; $display("FAIL zone2_f2: got lat=%0d m=%h dn=%h up=%h stray=%b want 10/04/04/00/0", lat, m, dn, up, st); end
    @(posedge clk); #1;
    tests++; if ({bus.key_down, bus.frame_done} !== 9'h0) begin
      fails++; $display("FAIL zone2_pulse_len: got dn=%h done=%b want 0", bus.key_down, bus.frame_done); end
  endtask

  task automatic test_release();
    int lat; logic [7:0] m, dn, up; logic [31:0] dbg; logic es, st;
    logic [7:0] pat [4] = '{8'h00, 8'h04, 8'h00, 8'h00};
    for (int f = 0; f < 4; f++) begin
      run_frame(pat[f], 9'h000, -1, 0, 0, lat, m, dn, up, dbg, es, st);
      exp_cnt++;
      if (f < 3) begin
        tests++; if ({m, dn, up} !== {8'h04, 16'h0}) begin fails++; $display("FAIL glitch f%0d: got m=%h dn=%h up=%h want 04/00/00", f, m, dn, up); end
      end else begin
        tests++; if ({m, dn, up} !== {8'h00, 8'h00, 8'h04}) begin fails++; $display("FAIL release: got m=%h dn=%h up=%h want 00/00/04", m, dn, up); end
      end
    end
  endtask

  task automatic test_threshold();
    int lat; logic [7:0] m, dn, up; logic [31:0] dbg; logic es, st;
    run_frame(8'h00, 9'h000, 5, 6, 0, lat, m, dn, up, dbg, es, st); exp_cnt++;
    tests++; if (m !== 8'h00) begin fails++; $display("FAIL th_eq_f1: got m=%h want 00", m); end
    run_frame(8'h00, 9'h000, 5, 6, 0, lat, m, dn, up, dbg, es, st); exp_cnt++;
    tests++; if ({m, dn} !== 16'h2020) begin fails++; $display("FAIL th_eq_f2: got m=%h dn=%h want 20/20", m, dn); end
    run_frame(8'h00, 9'h000, -1, 0, 0, lat, m, dn, up, dbg, es, st); exp_cnt++;
    run_frame(8'h00, 9'h000, -1, 0, 0, lat, m, dn, up, dbg, es, st); exp_cnt++;
    tests++; if ({m, up} !== 16'h0020) begin fails++; $display("FAIL th_release: got m=%h up=%h want 00/20", m, up); end
    for (int f = 0; f < 2; f++) begin
      run_frame(8'h00, 9'h000, 5, 5, 0, lat, m, dn, up, dbg, es, st); exp_cnt++;
      tests++; if ({m, dn} !== 16'h0000) begin fails++; $display("FAIL th_below f%0d: got m=%h dn=%h want 00/00", f, m, dn); end
    end
  endtask

  task automatic test_luma();
    int lat; logic [7:0] m, dn, up; logic [31:0] dbg; logic es, st;
    run_frame(8'h01, 9'h052, -1, 0, 0, lat, m, dn, up, dbg, es, st); exp_cnt++;
    tests++; if (dbg !== {exp_cnt, 8'h00, 16'd12}) begin fails++; $display("FAIL luma5_dark: got %h want %h", dbg, {exp_cnt, 8'h00, 16'd12}); end
    run_frame(8'h01, 9'h092, -1, 0, 0, lat, m, dn, up, dbg, es, st); exp_cnt++;
    tests++; if (dbg !== {exp_cnt, 8'h00, 16'd0}) begin fails++; $display("FAIL luma6_light: got %h want %h", dbg, {exp_cnt, 24'h0}); end
  endtask

  task automatic test_abort_accum();
    int lat; logic [7:0] m, dn, up; logic [31:0] dbg; logic es, st, seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      bus.frame_start = (i == 0); bus.pix_valid = 1'b1;
      bus.pix_data = pix_at(i % H, i / H, 8'h01, 9'h000, -1, 0);
      @(posedge clk); #1;
      if (bus.frame_done || bus.frame_err) seen = 1'b1;
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL abort_partial: got pulse=%b want 0", seen); end
    run_frame(8'h00, 9'h000, -1, 0, 0, lat, m, dn, up, dbg, es, st); exp_cnt++;
    tests++; if (es !== 1'b1) begin fails++; $display("FAIL abort_err: got %b want 1", es); end
    tests++; if ({lat, st} !== {32'd10, 1'b0}) begin fails++; $display("FAIL abort_restart: got lat=%0d stray=%b want 10/0", lat, st); end
    tests++; if (dbg !== {exp_cnt, 24'h0}) begin fails++; $display("FAIL abort_dbg: got %h want %h", dbg, {exp_cnt, 24'h0}); end
  endtask

  task automatic test_abort_eval();
    int lat; logic [7:0] m, dn, up; logic [31:0] dbg; logic es, st, seen;
    run_frame(8'h00, 9'h000, -1, 0, 4, lat, m, dn, up, dbg, es, st); exp_cnt++;
    tests++; if ({es, lat} !== {1'b1, 32'd10}) begin fails++; $display("FAIL eval_abort: got err=%b lat=%0d want 1/10", es, lat); end
    tests++; if (dbg !== {exp_cnt, 24'h0}) begin fails++; $display("FAIL eval_abort_dbg: got %h want %h", dbg, {exp_cnt, 24'h0}); end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.pix_valid = 1'b1; bus.pix_data = 9'h000;
      @(posedge clk); #1;
      if (bus.busy) seen = 1'b1;
    end
    bus.pix_valid = 1'b0;
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL eval_abort_idle: got busy=%b want 0", seen); end
    run_frame(8'h00, 9'h000, -1, 0, 0, lat, m, dn, up, dbg, es, st); exp_cnt++;
    tests++; if ({lat, es} !== {32'd10, 1'b0}) begin fails++; $display("FAIL eval_abort_next: got lat=%0d err=%b want 10/0", lat, es); end
  endtask

  initial begin
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.pix_data    = '0;
    rst             = 1'b1;
    exp_cnt         = 8'd0;
    test_reset();
    test_white();
    test_zone2();
    test_release();
    test_threshold();
    test_luma();
    test_abort_accum();
    test_abort_eval();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/key_zone_scanner.md
Name: key_zone_scanner

Overview:
- Sits downstream of the camera frame-buffer path and taps the same 9-bit RGB333 pixel stream that is written to frame memory.
- Splits a horizontal band of each frame into NUM_KEYS equal-width zones and counts the dark pixels in each zone.
- At frame end it thresholds the counts, debounces them across frames, and outputs a stable key-pressed mask plus press/release pulses for the tone stage and the dig_ctrl debug display.

Parameters:
- H_RES, 320, active pixels per line
- V_RES, 240, active lines per frame
- NUM_KEYS, 8, number of key zones; zone width ZONE_W = H_RES/NUM_KEYS (40)
- ROW_TOP, 200, first line of the scan band (inclusive)
- ROW_BOT, 219, last line of the scan band (inclusive)
- DARK_TH, 6, a pixel is dark when luma < DARK_TH
- COUNT_TH, 400, a zone reads raw-pressed when dark_count >= COUNT_TH
- STABLE_FRAMES, 2, number of consecutive evaluated frames with an unchanged raw value required before the mask bit changes

Ports:
- clk  in  1  single clock domain, same as the camera memory clock
- rst  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse marking pixel 0 of a new frame
- pix_valid  in  1  pix_data carries the next raster-order pixel
- pix_data  in  9  {r[8:6], g[5:3], b[2:0]}
- key_mask  out  NUM_KEYS  debounced pressed state; bit k = zone k, zone 0 is leftmost
- key_down  out  NUM_KEYS  one-cycle pulse on a 0->1 change of key_mask bits
- key_up  out  NUM_KEYS  one-cycle pulse on a 1->0 change of key_mask bits
- frame_done  out  1  one-cycle pulse when evaluation of a frame completes
- frame_err  out  1  one-cycle pulse when a frame is aborted
- busy  out  1  high in ACCUM or EVAL
- debug_out  out  32  {8'frame_cnt, 8'key_mask (zero-padded), 16'dark_count of zone 0 from last frame}

Behaviour:
- Reset: all outputs 0; state IDLE; counters, debounce counters and frame_cnt cleared.
- States: IDLE, ACCUM, EVAL, DONE.
- IDLE:
  - frame_start -> ACCUM. In that cycle x, y, zone index and all dark counters clear.
  - A pix_valid coincident with frame_start is pixel (0,0) and is counted.
  - pix_valid without a frame start is ignored.
- ACCUM:
  - On each pix_valid, advance x.
  - x wraps H_RES-1 -> 0 and increments y.
  - The zone index advances every ZONE_W pixels via a sub-counter; no divider.
  - luma = r+g+b, 5 bits, range 0..21.
  - If ROW_TOP <= y <= ROW_BOT and luma < DARK_TH, increment dark_count[zone].
  - dark_count is 16 bits and saturates at 0xFFFF.
  - The cycle that accepts pixel (H_RES-1, V_RES-1) moves the FSM to EVAL on the next cycle.
- Short frame: frame_start in ACCUM before the last pixel.
  - Pulse frame_err.
  - Discard counts and restart ACCUM as in the IDLE entry; the coincident pixel counts as (0,0).
  - Masks are unchanged.
- EVAL: evaluates one key per cycle, k = 0..NUM_KEYS-1, taking NUM_KEYS cycles.
  - raw = (dark_count[k] >= COUNT_TH).
  - If raw == key_mask[k], stab[k] clears.
  - Otherwise stab[k] increments. When it reaches STABLE_FRAMES, key_mask[k] toggles, stab[k] clears, and the matching key_down/key_up bit is set.
  - pix_valid is ignored in EVAL.
  - frame_start in EVAL pulses frame_err; evaluation still completes, then the FSM goes to IDLE, so the next frame is lost.
- DONE: one cycle.
  - Pulse frame_done.
  - Emit the accumulated key_down/key_up bits as a single one-cycle pulse, aligned with frame_done.
  - Increment frame_cnt, wrapping at 8 bits.
  - Go to IDLE.
- Latency: frame_done asserts NUM_KEYS+2 cycles after the last pixel is accepted (10 at defaults).
- key_mask updates in the same cycle as frame_done.
- rst mid-frame returns the block to IDLE immediately and emits no pulses.

Test Plan:
- Reset: assert rst during ACCUM -> next cycle all outputs 0, busy 0; a later full frame evaluates normally.
- All-white frames (pix_data=0x1FF) for 3 frames -> key_mask=0x00, no key_down; frame_done 10 cycles after each last pixel.
- Zone 2 black (x 80..119, y 200..219, pix 0x000), rest white:
  - frame 1 -> mask 0x00;
  - frame 2 -> key_mask=0x04 with key_down=0x04 for one cycle, aligned with frame_done.
- Threshold boundary: exactly 400 dark pixels in zone 5 for 2 frames -> mask bit5=1; 399 dark pixels -> bit5 stays 0.
- Release and glitch: after mask=0x04, white zone 2 for 1 frame then black again -> no change. White for 2 frames -> key_up=0x04, mask=0x00.
- Aborts:
  - frame_start after 1000 pixels -> frame_err pulse; no frame_done for the aborted frame; the next complete frame is counted from 0.
  - frame_start during EVAL -> frame_err pulse, that frame's frame_done still asserts, and the FSM returns to IDLE.
